// File: rtl/if_mem_ctrl_pkg.sv
// Shared types for the instruction-fetch memory controller: FSM states,
// byte-count width and the little-endian byte-lane insert helper.
package if_mem_ctrl_pkg;

  localparam int unsigned IFM_BCNT_W = 2;
  localparam int unsigned IFM_INST_W = 32;

  typedef enum logic [1:0] {
    IFM_IDLE,
    IFM_ISSUE,
    IFM_DRAIN,
    IFM_DONE
  } ifm_state_e;

  function automatic logic [IFM_INST_W-1:0] ifm_put_byte(
    input logic [IFM_INST_W-1:0] word,
    input logic [IFM_BCNT_W-1:0] idx,
    input logic [7:0]            b
  );
    logic [IFM_INST_W-1:0] w;
    w = word;
    w[{idx, 3'b000} +: 8] = b;
    return w;
  endfunction

endpackage

// File: rtl/if_last_buf.sv
// One-entry last-fetch buffer {valid, addr, inst} with hit compare.
// Only built when IF_LASTBUF_EN is defined.
`ifdef IF_LASTBUF_EN
module if_last_buf #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_wr,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [31:0]       i_wr_inst,
  input  logic              i_inv,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic              o_hit,
  output logic [31:0]       o_inst
);

  logic              r_valid;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_inst;

  // Invalidate wins over a same-cycle write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_valid <= 1'b0;
      r_addr  <= '0;
      r_inst  <= '0;
    end else if (i_inv) begin
      r_valid <= 1'b0;
    end else if (i_wr) begin
      r_valid <= 1'b1;
      r_addr  <= i_wr_addr;
      r_inst  <= i_wr_inst;
    end
  end

  always_comb begin
    o_hit  = r_valid && !i_inv && (i_rd_addr == r_addr);
    o_inst = r_inst;
  end

endmodule
`endif

// File: rtl/if_mem_ctrl.sv
// Instruction-fetch memory controller: four byte reads from shared RAM assembled
// little-endian into one word. Optional last-fetch buffer under IF_LASTBUF_EN.
module if_mem_ctrl
  import if_mem_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ram_read,
  input  logic [ADDR_W-1:0] ram_addr,
  input  logic              br_flush,
  output logic              ram_ready,
  output logic [31:0]       ram_data,
  input  logic              mem_grant,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_din,
  input  logic              inv
);

  ifm_state_e            r_state;
  logic [ADDR_W-1:0]     r_base;
  logic [ADDR_W-1:0]     r_mem_addr;
  logic [IFM_BCNT_W-1:0] r_cnt;
  logic [IFM_BCNT_W-1:0] r_pidx;
  logic                  r_pend;
  logic                  r_mem_req;
  logic                  r_ram_ready;
  logic [31:0]           r_ram_data;

  logic                  w_abort;
  logic                  w_hit;
  logic [31:0]           w_buf_inst;

`ifdef IF_LASTBUF_EN
  if_last_buf #(.ADDR_W(ADDR_W)) u_last_buf (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_wr      (r_state == IFM_DONE),
    .i_wr_addr (r_base),
    .i_wr_inst (r_ram_data),
    .i_inv     (inv),
    .i_rd_addr (ram_addr),
    .o_hit     (w_hit),
    .o_inst    (w_buf_inst)
  );
`else
  logic w_unused_inv;
  assign w_unused_inv = inv;
  assign w_hit        = 1'b0;
  assign w_buf_inst   = '0;
`endif

  assign w_abort = br_flush || !ram_read || (ram_addr != r_base);

  // mem_addr is registered, so the byte issued in cycle t lands on mem_din in t+1
  // and is written into its lane at the end of t+1 through r_pend/r_pidx.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IFM_IDLE;
      r_base      <= '0;
      r_mem_addr  <= '0;
      r_cnt       <= '0;
      r_pidx      <= '0;
      r_pend      <= 1'b0;
      r_mem_req   <= 1'b0;
      r_ram_ready <= 1'b0;
      r_ram_data  <= '0;
    end else begin
      r_ram_ready <= 1'b0;
      r_pend      <= 1'b0;
      case (r_state)
        IFM_IDLE: begin
          r_mem_req <= 1'b0;
          if (ram_read && !br_flush) begin
            r_base <= ram_addr;
            if (w_hit) begin
              r_ram_data  <= w_buf_inst;
              r_ram_ready <= 1'b1;
              r_state     <= IFM_DONE;
            end else begin
              r_cnt      <= '0;
              r_mem_req  <= 1'b1;
              r_mem_addr <= ram_addr;
              r_state    <= IFM_ISSUE;
            end
          end
        end
        IFM_ISSUE: begin
          if (w_abort) begin
            r_mem_req <= 1'b0;
            r_state   <= IFM_IDLE;
          end else begin
            if (r_pend) r_ram_data <= ifm_put_byte(r_ram_data, r_pidx, mem_din);
            if (mem_grant) begin
              r_pend <= 1'b1;
              r_pidx <= r_cnt;
              if (r_cnt == IFM_BCNT_W'(3)) begin
                r_mem_req <= 1'b0;
                r_state   <= IFM_DRAIN;
              end else begin
                r_cnt      <= r_cnt + IFM_BCNT_W'(1);
                r_mem_addr <= r_mem_addr + ADDR_W'(1);
              end
            end
          end
        end
        IFM_DRAIN: begin
          if (w_abort) begin
            r_state <= IFM_IDLE;
          end else if (r_pend) begin
            r_ram_data  <= ifm_put_byte(r_ram_data, r_pidx, mem_din);
            r_ram_ready <= 1'b1;
            r_state     <= IFM_DONE;
          end
        end
        IFM_DONE: r_state <= IFM_IDLE;
        default:  r_state <= IFM_IDLE;
      endcase
    end
  end

  assign ram_ready = r_ram_ready;
  assign ram_data  = r_ram_data;
  assign mem_req   = r_mem_req;
  assign mem_addr  = r_mem_addr;

endmodule

// File: tb/tb_if_mem_ctrl.sv
// Scoreboard bench for if_mem_ctrl: stimulus pushes expected {word, cycle},
// a negedge monitor pops and compares on every ram_ready pulse.
module tb_if_mem_ctrl;

  localparam int unsigned ADDR_W = 32;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              ram_read = 1'b0;
  logic [ADDR_W-1:0] ram_addr = '0;
  logic              br_flush = 1'b0;
  logic              ram_ready;
  logic [31:0]       ram_data;
  logic              mem_grant = 1'b1;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_din = '0;
  logic              inv = 1'b1;

  logic [7:0]        ram [0:1023];
  int unsigned       cyc = 0;

  typedef struct {
    logic [31:0] data;
    int unsigned cyc;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  int          checks = 0;
  int          errors = 0;
  int unsigned c0, c1, c2;

  if_mem_ctrl #(.ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .ram_read  (ram_read),
    .ram_addr  (ram_addr),
    .br_flush  (br_flush),
    .ram_ready (ram_ready),
    .ram_data  (ram_data),
    .mem_grant (mem_grant),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_din   (mem_din),
    .inv       (inv)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) mem_din <= ram[mem_addr[9:0]];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n && ram_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL ready_unexpected: got pulse at cycle %0d expected none", cyc);
      end else begin
        e = sb.pop_front();
        check("ready_data", ram_data, e.data);
        check("ready_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int unsigned c);
    while (cyc < c) step();
  endtask

  task automatic expect_ready(input logic [31:0] d, input int unsigned c);
    sb.push_back('{d, c});
  endtask

  task automatic drain(input string name);
    int unsigned n = 0;
    while (sb.size() != 0 && n < 20) begin
      step();
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout: got %0d pending readies expected 0", name, sb.size());
      sb.delete();
    end
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test expected $finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 1024; i++) ram[i] = 8'(i) ^ 8'h5A;
    ram[10'h100] = 8'h13; ram[10'h101] = 8'h05; ram[10'h102] = 8'h10; ram[10'h103] = 8'h00;
    ram[10'h200] = 8'h78; ram[10'h201] = 8'h56; ram[10'h202] = 8'h34; ram[10'h203] = 8'h12;
    ram[10'h3FE] = 8'hAA; ram[10'h3FF] = 8'hBB; ram[10'h000] = 8'hCC; ram[10'h001] = 8'hDD;

    step(); step();
    check("rst_ready", 32'(ram_ready), 32'h0);
    check("rst_data", ram_data, 32'h0);
    check("rst_req", 32'(mem_req), 32'h0);
    check("rst_addr", mem_addr, 32'h0);
    reset_n = 1'b1;
    step();

    // 1: basic fetch with constant grant
    c0 = cyc; ram_addr = 32'h100; ram_read = 1'b1;
    expect_ready(32'h0010_0513, c0 + 6);
    wait_cyc(c0 + 1);
    check("t1_req", 32'(mem_req), 32'h1);
    check("t1_addr0", mem_addr, 32'h100);
    wait_cyc(c0 + 6);
    ram_read = 1'b0;
    drain("t1");

    // 2: grant withheld in cycles 2-3
    c0 = cyc; ram_addr = 32'h100; ram_read = 1'b1;
    expect_ready(32'h0010_0513, c0 + 8);
    wait_cyc(c0 + 2);
    mem_grant = 1'b0;
    check("t2_addr_c2", mem_addr, 32'h101);
    check("t2_req_c2", 32'(mem_req), 32'h1);
    step();
    check("t2_addr_c3", mem_addr, 32'h101);
    step();
    mem_grant = 1'b1;
    wait_cyc(c0 + 8);
    ram_read = 1'b0;
    drain("t2");

    // 3: flush mid-fetch, then new request at 0x200
    c0 = cyc; ram_addr = 32'h100; ram_read = 1'b1;
    wait_cyc(c0 + 3);
    br_flush = 1'b1;
    step();
    br_flush = 1'b0; ram_addr = 32'h200;
    check("t3_req_idle", 32'(mem_req), 32'h0);
    expect_ready(32'h1234_5678, c0 + 10);
    step();
    check("t3_addr_new", mem_addr, 32'h200);
    wait_cyc(c0 + 10);
    ram_read = 1'b0;
    drain("t3");

    // 3b: address change aborts; new fetch wraps past the top of the space
    c0 = cyc; ram_addr = 32'h200; ram_read = 1'b1;
    wait_cyc(c0 + 2);
    ram_addr = 32'hFFFF_FFFE;
    expect_ready(32'hDDCC_BBAA, c0 + 9);
    wait_cyc(c0 + 4);
    check("t3b_addr_base", mem_addr, 32'hFFFF_FFFE);
    wait_cyc(c0 + 6);
    check("t3b_addr_wrap", mem_addr, 32'h0);
    wait_cyc(c0 + 9);
    ram_read = 1'b0;
    drain("t3b");

    // 4: ram_read held through DONE
    c0 = cyc; ram_addr = 32'h100; ram_read = 1'b1;
    expect_ready(32'h0010_0513, c0 + 6);
    wait_cyc(c0 + 7);
    check("t4_req_after_done", 32'(mem_req), 32'h0);
    step();
    check("t4_req_reissue", 32'(mem_req), 32'h1);
    check("t4_addr_reissue", mem_addr, 32'h100);
    ram_read = 1'b0;
    step();
    check("t4_req_abort", 32'(mem_req), 32'h0);
    drain("t4");
    repeat (8) step();

    // 5: async reset in the middle of ISSUE
    c0 = cyc; ram_addr = 32'h100; ram_read = 1'b1;
    wait_cyc(c0 + 3);
    #1 reset_n = 1'b0;
    #1;
    check("t5_rst_ready", 32'(ram_ready), 32'h0);
    check("t5_rst_data", ram_data, 32'h0);
    check("t5_rst_req", 32'(mem_req), 32'h0);
    check("t5_rst_addr", mem_addr, 32'h0);
    ram_read = 1'b0;
    step();
    reset_n = 1'b1;
    step();
    c0 = cyc; ram_addr = 32'h100; ram_read = 1'b1;
    expect_ready(32'h0010_0513, c0 + 6);
    wait_cyc(c0 + 6);
    ram_read = 1'b0;
    drain("t5");

`ifdef IF_LASTBUF_EN
    // 6: last-fetch buffer hit, then miss after invalidate
    inv = 1'b0;
    c0 = cyc; ram_addr = 32'h100; ram_read = 1'b1;
    expect_ready(32'h0010_0513, c0 + 6);
    wait_cyc(c0 + 6);
    ram_read = 1'b0;
    step();
    c1 = cyc; ram_read = 1'b1;
    expect_ready(32'h0010_0513, c1 + 1);
    step();
    check("t6_hit_req", 32'(mem_req), 32'h0);
    ram_read = 1'b0;
    drain("t6_hit");
    c2 = cyc; ram_read = 1'b1; inv = 1'b1;
    expect_ready(32'h0010_0513, c2 + 6);
    step();
    check("t6_miss_req", 32'(mem_req), 32'h1);
    wait_cyc(c2 + 6);
    ram_read = 1'b0;
    drain("t6_miss");
`endif

    repeat (4) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
